// File: rtl/riscv_pkg.sv
// Shared RV32 instruction-encoding constants used by fetch and decode.
// Field positions assume the fixed 32-bit base encoding.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OP_IMM = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6f,
    OPC_SYSTEM = 7'h73
  } opcode_e;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned F7_LSB  = 25;

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of a 32-bit instruction into decode fields,
// substituting a NOP word when asked so the consumer sees a bubble.
module instr_field_split
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = riscv_pkg::NOP_INSTR
) (
  input  logic [31:0] word_i,
  input  logic        use_nop_i,
  output logic [6:0]  opcode_o,
  output logic [2:0]  fun_3_o,
  output logic [6:0]  fun_7_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic [4:0]  rd_addr_o,
  output logic [24:0] instr_31_7_o
);

  logic [31:0] sel_word_s;

  assign sel_word_s   = use_nop_i ? NOP_WORD : word_i;

  assign opcode_o     = sel_word_s[OPC_LSB +: 7];
  assign rd_addr_o    = sel_word_s[RD_LSB  +: 5];
  assign fun_3_o      = sel_word_s[F3_LSB  +: 3];
  assign rs1_addr_o   = sel_word_s[RS1_LSB +: 5];
  assign rs2_addr_o   = sel_word_s[RS2_LSB +: 5];
  assign fun_7_o      = sel_word_s[F7_LSB  +: 7];
  assign instr_31_7_o = sel_word_s[31:RD_LSB];

endmodule

// File: rtl/instr_fetch_queue.sv
// Circular instruction buffer between I-memory response and decode; the
// head entry is split into decode fields, or a NOP bubble when empty/flushing.
module instr_fetch_queue #(
  parameter int unsigned ILEN      = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       flush_in,
  input  logic                       in_valid_in,
  output logic                       in_ready_o,
  input  logic [ILEN-1:0]            instr_in,
  input  logic [PC_W-1:0]            pc_in,
  output logic                       out_valid_o,
  input  logic                       out_ready_in,
  output logic [PC_W-1:0]            pc_o,
  output logic [6:0]                 opcode_o,
  output logic [2:0]                 fun_3_o,
  output logic [6:0]                 fun_7_o,
  output logic [4:0]                 rs1_addr_o,
  output logic [4:0]                 rs2_addr_o,
  output logic [4:0]                 rd_addr_o,
  output logic [24:0]                instr_31_7_o,
  output logic                       bubble_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_fetch_queue: DEPTH must be a power of two and at least 2");
  end

  logic [ILEN-1:0]  mem_instr_q [DEPTH];
  logic [PC_W-1:0]  mem_pc_q    [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_s, pop_s;

  // Readiness comes only from registered occupancy, so a full queue
  // cannot accept even when the head is leaving this cycle.
  assign in_ready_o  = (count_q != CNT_W'(DEPTH));
  assign out_valid_o = (count_q != '0) & ~flush_in;
  assign push_s      = in_valid_in & in_ready_o;
  assign pop_s       = out_valid_o & out_ready_in;
  assign count_o     = count_q;
  assign bubble_o    = ~out_valid_o;
  assign pc_o        = out_valid_o ? mem_pc_q[rptr_q] : '0;

  // Next-state for pointers and occupancy; flush overrides any transfer.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_in) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_s) begin
        wptr_d = wptr_q + PTR_W'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + PTR_W'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk_in) begin
    if (push_s && !flush_in) begin
      mem_instr_q[wptr_q] <= instr_in;
      mem_pc_q[wptr_q]    <= pc_in;
    end
  end

  instr_field_split #(
    .NOP_WORD (NOP_INSTR)
  ) u_split (
    .word_i       (mem_instr_q[rptr_q][31:0]),
    .use_nop_i    (~out_valid_o),
    .opcode_o     (opcode_o),
    .fun_3_o      (fun_3_o),
    .fun_7_o      (fun_7_o),
    .rs1_addr_o   (rs1_addr_o),
    .rs2_addr_o   (rs2_addr_o),
    .rd_addr_o    (rd_addr_o),
    .instr_31_7_o (instr_31_7_o)
  );

endmodule
